// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame receiver: frame width, bit-count width and FSM states.
package spi_pkg;

    localparam int unsigned SPI_DATA_WIDTH = 24;
    localparam int unsigned SPI_CNT_W      = $clog2(SPI_DATA_WIDTH + 2);

    typedef enum logic [1:0] {
        StArming,
        StIdle,
        StShift,
        StDone
    } spi_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous input, followed by a registered
// edge detector producing the synchronized level and single-cycle rise/fall pulses.
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_receiver.sv
// SPI responder for the 24-bit DAC frame protocol: oversamples sclk/sync_n/sdi in the
// clk_50 domain and emits parallel frames. Optional readback echo on sdo: SPI_RX_ECHO_EN.
module spi_receiver
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  sync_n,
    input  logic                  sdi,
    output logic                  sdo,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  data_valid,
    output logic                  frame_error,
    output logic                  busy
);

    localparam int unsigned         CNT_W    = $clog2(DATA_WIDTH + 2);
    localparam logic [CNT_W-1:0]    CntFull  = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0]    CntSat   = CNT_W'(DATA_WIDTH + 1);

    logic sclk_level, sclk_rise, sclk_fall;
    logic sync_level, sync_rise, sync_fall;
    logic sdi_level, sdi_rise, sdi_fall;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clock (clock),
        .reset (reset),
        .din   (sclk),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_n_sync (
        .clock (clock),
        .reset (reset),
        .din   (sync_n),
        .level (sync_level),
        .rise  (sync_rise),
        .fall  (sync_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sdi_sync (
        .clock (clock),
        .reset (reset),
        .din   (sdi),
        .level (sdi_level),
        .rise  (sdi_rise),
        .fall  (sdi_fall)
    );

    // IDLE starts on the low level, so a fall detected during DONE is still taken.
    logic unused_edges;
    assign unused_edges = sclk_level | sync_fall | sdi_rise | sdi_fall;

    spi_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   data_valid_q, data_valid_d;
    logic                   frame_error_q, frame_error_d;
    logic                   busy_q, busy_d;
    logic                   frame_start;

    assign frame_start = (state_q == StIdle) && !sync_level;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        data_d        = data_q;
        data_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        busy_d        = busy_q;
        unique case (state_q)
            StArming: begin
                if (sync_level) state_d = StIdle;
            end
            StIdle: begin
                if (frame_start) begin
                    cnt_d   = '0;
                    shift_d = '0;
                    busy_d  = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                // A coincident sclk fall is dropped when the frame closes.
                if (sync_rise) begin
                    state_d = StDone;
                end else if (sclk_fall) begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], sdi_level};
                    if (cnt_q != CntSat) cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
                if (cnt_q == CntFull) begin
                    data_d       = shift_q;
                    data_valid_d = 1'b1;
                end else begin
                    frame_error_d = 1'b1;
                end
            end
            default: state_d = StArming;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StArming;
            cnt_q         <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
        end
    end

    assign data        = data_q;
    assign data_valid  = data_valid_q;
    assign frame_error = frame_error_q;
    assign busy        = busy_q;

`ifdef SPI_RX_ECHO_EN
    logic [DATA_WIDTH-1:0] echo_q, echo_d;

    // Master samples sdo on sclk fall, so advance on sclk rise.
    always_comb begin
        echo_d = echo_q;
        if (frame_start) begin
            echo_d = data_q;
        end else if ((state_q == StShift) && sclk_rise) begin
            echo_d = {echo_q[DATA_WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) echo_q <= '0;
        else       echo_q <= echo_d;
    end

    assign sdo = (state_q == StShift) ? echo_q[DATA_WIDTH-1] : 1'b0;
`else
    logic unused_sclk_rise;
    assign unused_sclk_rise = sclk_rise;
    assign sdo              = 1'b0;
`endif

endmodule
